// File: rtl/jb_debounce_bank.sv
// Multi-channel debouncer: per-channel synchronizer, stability counter and
// accepted-level register, with registered rise/fall pulses and sticky flags.
module jb_debounce_bank #(
  parameter int                NUM_CH        = 8,
  parameter int                SYNC_STAGES   = 2,
  parameter int                STABLE_CYCLES = 16,
  parameter int                COUNTER_BITS  = 8,
  parameter logic [NUM_CH-1:0] RESET_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] evt_clr,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              changed,
  output logic [NUM_CH-1:0] rise_sticky,
  output logic [NUM_CH-1:0] fall_sticky
);

  localparam logic [COUNTER_BITS-1:0] CNT_MAX = COUNTER_BITS'(STABLE_CYCLES - 1);

  // sync_q[k] holds stage k of every channel; the last stage is the filtered sample
  logic [NUM_CH-1:0]       sync_q [SYNC_STAGES+1];
  logic [COUNTER_BITS-1:0] cnt_q  [NUM_CH];

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] accept;

  assign s      = sync_q[SYNC_STAGES];
  assign stable = ~(sync_q[SYNC_STAGES] ^ sync_q[SYNC_STAGES-1]);
  assign accept = done & (s ^ dout);

  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      done[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      dout        <= RESET_VAL;
      rise        <= '0;
      fall        <= '0;
      changed     <= 1'b0;
      rise_sticky <= '0;
      fall_sticky <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k <= SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      // Any movement of the filtered sample restarts the count; saturate once done
      for (int i = 0; i < NUM_CH; i++) begin
        if (!stable[i]) begin
          cnt_q[i] <= '0;
        end else if (!done[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      dout    <= dout ^ accept;
      rise    <= accept & s;
      fall    <= accept & ~s;
      changed <= |accept;
      // A pulse landing in the same cycle as a clear keeps the flag set
      rise_sticky <= (rise_sticky & ~evt_clr) | rise;
      fall_sticky <= (fall_sticky & ~evt_clr) | fall;
    end
  end

endmodule

// File: tb/tb_jb_debounce_bank.sv
// Directed bench for jb_debounce_bank (4 channels, reset level 4'b0101); edge
// numbers in each step count from the first edge that samples the new din.
module tb_jb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] evt_clr;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;
  logic [3:0] rise_sticky;
  logic [3:0] fall_sticky;

  int checks   = 0;
  int failures = 0;
  int cur_edge = 0;

  logic [3:0] exp_dout;
  logic [3:0] exp_rs;
  logic [3:0] exp_fs;

  always #5 clk = ~clk;

  jb_debounce_bank #(
    .NUM_CH       (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(16),
    .COUNTER_BITS (8),
    .RESET_VAL    (4'b0101)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .evt_clr    (evt_clr),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed),
    .rise_sticky(rise_sticky),
    .fall_sticky(fall_sticky)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, cur_edge, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic [3:0] c);
    din     = d;
    evt_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input logic [3:0] exp_rise, input logic [3:0] exp_fall);
    checkOutput("rise", rise, exp_rise);
    checkOutput("fall", fall, exp_fall);
    checkOutput("changed", changed, (exp_rise | exp_fall) != 4'b0000);
    checkOutput("dout", dout, exp_dout);
    checkOutput("rise_sticky", rise_sticky, exp_rs);
    checkOutput("fall_sticky", fall_sticky, exp_fs);
  endtask

  // Pulses expected at pulse_edge (0 = none); stickies follow one edge later
  task automatic runEdges(input int first, input int last, input int pulse_edge,
                          input logic [3:0] rmask, input logic [3:0] fmask);
    for (int e = first; e <= last; e++) begin
      tick();
      cur_edge = e;
      if (e == pulse_edge) exp_dout = (exp_dout | rmask) & ~fmask;
      if (pulse_edge != 0 && e == pulse_edge + 1) begin
        exp_rs = exp_rs | rmask;
        exp_fs = exp_fs | fmask;
      end
      if (e == pulse_edge) checkAll(rmask, fmask);
      else                 checkAll(4'b0000, 4'b0000);
    end
  endtask

  initial begin
    // Reset state and quiet release
    rst = 1'b1;
    applyStimulus(4'b0101, 4'b0000);
    tick(); tick(); tick();
    exp_dout = 4'b0101;
    exp_rs   = 4'b0000;
    exp_fs   = 4'b0000;
    checkAll(4'b0000, 4'b0000);
    rst = 1'b0;
    runEdges(1, 50, 0, 4'b0000, 4'b0000);

    // Clean rise then fall on channel 1
    applyStimulus(4'b0111, 4'b0000);
    runEdges(1, 25, 19, 4'b0010, 4'b0000);
    applyStimulus(4'b0101, 4'b0000);
    runEdges(1, 25, 19, 4'b0000, 4'b0010);

    // Channel 3: 15-cycle pulse rejected, 17-cycle pulse accepted
    applyStimulus(4'b1101, 4'b0000);
    runEdges(1, 15, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b0101, 4'b0000);
    runEdges(1, 25, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b1101, 4'b0000);
    runEdges(1, 17, 19, 4'b1000, 4'b0000);
    applyStimulus(4'b0101, 4'b0000);
    runEdges(18, 25, 19, 4'b1000, 4'b0000);
    runEdges(9, 25, 19, 4'b0000, 4'b1000);

    // Channel 0 bounce: settle low, toggle every 5 cycles, then hold high
    applyStimulus(4'b0100, 4'b0000);
    runEdges(1, 25, 19, 4'b0000, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      applyStimulus((k % 2 == 0) ? 4'b0101 : 4'b0100, 4'b0000);
      runEdges(1, 5, 0, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0101, 4'b0000);
    runEdges(1, 25, 19, 4'b0001, 4'b0000);

    // Simultaneous rise on channel 0 and fall on channel 2
    applyStimulus(4'b0100, 4'b0000);
    runEdges(1, 25, 19, 4'b0000, 4'b0001);
    applyStimulus(4'b0001, 4'b0000);
    runEdges(1, 25, 19, 4'b0001, 4'b0100);

    // Plain clear of channel 0 flags
    applyStimulus(4'b0001, 4'b0001);
    tick();
    cur_edge = 1;
    exp_rs = exp_rs & ~4'b0001;
    exp_fs = exp_fs & ~4'b0001;
    checkAll(4'b0000, 4'b0000);

    // Clear coinciding with a new rise[0]: set wins on rise_sticky[0]
    applyStimulus(4'b0000, 4'b0000);
    runEdges(1, 25, 19, 4'b0000, 4'b0001);
    applyStimulus(4'b0001, 4'b0000);
    runEdges(1, 19, 19, 4'b0001, 4'b0000);
    applyStimulus(4'b0001, 4'b0001);
    exp_fs = exp_fs & ~4'b0001;
    runEdges(20, 20, 19, 4'b0001, 4'b0000);
    applyStimulus(4'b0001, 4'b0000);
    runEdges(21, 23, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b0001, 4'b0001);
    tick();
    cur_edge = 24;
    exp_rs = exp_rs & ~4'b0001;
    checkAll(4'b0000, 4'b0000);
    applyStimulus(4'b0001, 4'b0000);
    runEdges(25, 27, 0, 4'b0000, 4'b0000);

    // Restore channel 2 high so reset leaves every other channel at its reset level
    applyStimulus(4'b0101, 4'b0000);
    runEdges(1, 25, 19, 4'b0100, 4'b0000);

    // Reset in the middle of a pending channel 1 rise
    applyStimulus(4'b0111, 4'b0000);
    runEdges(1, 9, 0, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur_edge = 10;
    exp_dout = 4'b0101;
    exp_rs   = 4'b0000;
    exp_fs   = 4'b0000;
    checkAll(4'b0000, 4'b0000);
    runEdges(1, 25, 19, 4'b0010, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jb_debounce_bank.md
# jb_debounce_bank

Multi-channel debouncer: synchronizes `NUM_CH` asynchronous inputs, filters each channel independently, and publishes a debounced level. For every accepted transition it also produces single-cycle rise/fall pulses and sticky, software-clearable event flags. It sits between board pins (buttons, DIP switches, slow status lines) and register-map or control logic. It replaces single-bit debouncers where per-edge events and a defined reset state are needed.

## Interface
- `NUM_CH`, 8: number of independent channels (>=1).
- `SYNC_STAGES`, 2: synchronizer flops per channel (>=1).
- `STABLE_CYCLES`, 16: clk cycles the synchronized input must stay unchanged before it is accepted (1 .. 2**COUNTER_BITS).
- `COUNTER_BITS`, 8: width of each per-channel stability counter.
- `RESET_VAL`, {NUM_CH{1'b0}}: per-channel reset level of the sync chain and `dout`.

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `rst` in 1: synchronous, active-high reset.
- `din` in NUM_CH: raw asynchronous inputs.
- `evt_clr` in NUM_CH: per-channel clear for the sticky flags. Level-sampled each cycle.
- `dout` out NUM_CH: debounced levels.
- `rise` out NUM_CH: one-cycle pulse when `dout[i]` goes 0->1.
- `fall` out NUM_CH: one-cycle pulse when `dout[i]` goes 1->0.
- `changed` out 1: OR-reduction of `rise | fall`, registered alongside them.
- `rise_sticky` out NUM_CH: set by `rise[i]`, held until cleared.
- `fall_sticky` out NUM_CH: set by `fall[i]`, held until cleared.

## Operation
- Per channel `i`: `sync[i][0..SYNC_STAGES]` shift register. `sync[0]` samples `din[i]`. `sync[SYNC_STAGES]` is the filtered sample `s`.
- `stable[i] = (sync[SYNC_STAGES] == sync[SYNC_STAGES-1])`.
- Counter `cnt[i]`:
  - Cleared to 0 when `!stable`.
  - Otherwise increments, saturating at `STABLE_CYCLES-1`.
  - No wrap-around.
- `done[i] = (cnt[i] == STABLE_CYCLES-1)`.
  - When `done` and `s != dout[i]`: `dout[i] <= s`, and the matching `rise`/`fall` pulse is asserted in the same cycle `dout` updates.
  - When `done` and `s == dout[i]`: nothing changes.
- `rise`/`fall`/`changed` are registered and high for exactly one cycle per accepted transition. `rise[i]` and `fall[i]` are never high together.
- Sticky flags: set on the pulse, cleared by `evt_clr[i]`. If set and clear occur in the same cycle, **set wins**: the flag stays 1 and the event is not lost.
- Channels are fully independent. Simultaneous transitions on any subset of channels are each reported in their own bits.
- Reset (`rst`=1 at a clk edge):
  - `sync[i][*]` <= `RESET_VAL[i]`, `dout` <= `RESET_VAL`, `cnt` <= 0.
  - `rise`, `fall`, `changed`, `rise_sticky`, `fall_sticky` <= 0.
  - Reset mid-count discards any pending transition.
  - Leaving reset never produces a pulse while `din == RESET_VAL`.

## Timing
- Latency: `din[i]` changes and stays steady, and edge 1 is the first edge that samples the new value. Then `dout[i]`, `rise`/`fall` and `changed` update at edge `SYNC_STAGES + STABLE_CYCLES + 1`. The sticky flag sets one edge later.
- Default parameters give edge 19 for `dout`/pulse and edge 20 for sticky.
- Glitch rule: any change of `s` restarts the count from 0. A synchronized level must persist `STABLE_CYCLES` consecutive cycles to be accepted.
- A `din` pulse whose synchronized width is `<= STABLE_CYCLES - 1` cycles never reaches `dout`.
- A change back to the current `dout` before acceptance produces no event.
- `evt_clr` takes effect on the next edge. The sticky reads 0 the cycle after a clear, unless re-set in that same cycle.
- Throughput: at most one accepted transition per channel per `STABLE_CYCLES + 1` cycles.

## Test plan
Parameters unless stated: `NUM_CH`=4, `SYNC_STAGES`=2, `STABLE_CYCLES`=16, `RESET_VAL`=4'b0101.

- **Reset state:** hold `rst` 3 cycles with `din`=4'b0101, then release.
  - Required: `dout`=4'b0101.
  - Required: no `rise`/`fall`/`changed` for 50 cycles; stickies 0.
- **Clean edge:** `din[1]` 0->1 at edge 1.
  - Required: `dout[1]`=1 and `rise[1]`=1 for exactly one cycle at edge 19.
  - Required: `changed` pulses with `rise[1]`; `rise_sticky[1]`=1 from edge 20.
  - Required: `din[1]` 1->0 later gives `fall[1]` at the corresponding edge 19.
- **Glitch rejection:** `din[3]` high for 15 cycles, then low.
  - Required: no event, `dout[3]` stays 0.
  - Required: repeating with 17 cycles high gives one `rise[3]` followed later by one `fall[3]`.
- **Bounce:** `din[0]` toggles every 5 cycles for 100 cycles, then stays 1.
  - Required: exactly one `rise[0]`, 19 edges after the final toggle.
  - Required: no `fall[0]`.
- **Simultaneous / sticky clear:** `din[0]` and `din[2]` change on the same edge.
  - Required: `rise[0]` and `fall[2]` assert together, and `changed` pulses once.
  - Required: `evt_clr`=4'b0001 asserted on the same cycle a new `rise[0]` sets leaves `rise_sticky[0]`=1.
  - Required: `evt_clr` alone clears it on the next edge.
- **Reset mid-operation:** `din[1]` 0->1, then assert `rst` at edge 10.
  - Required: no `rise[1]`, and `dout[1]` returns to 0.
  - Required: after release with `din[1]` still 1, `rise[1]` fires 19 edges after the first post-reset edge.
